ram_dump_ctrl: RTL and testbench

Read-out sequencer that sits directly downstream of the 256x8 on-chip RAM. On a start pulse it walks a fixed address window and captures each RAM output word, accounting for the RAM's registered read latency. It hands each byte to the UART transmitter over a valid/ready handshake, so RAM contents can be dumped to the host over the serial link.

---
 rtl/ram_dump_ctrl_if.sv | 25 ++
 rtl/ram_dump_ctrl.sv | 140 ++++++++++++++
 tb/tb_ram_dump_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_ctrl_if.sv
// Bus between the RAM dump sequencer, the 256x8 RAM read port and the UART TX handshake.
`timescale 1ns/1ps
interface ram_dump_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, ram_q, tx_ready,
    output ram_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, ram_q, tx_ready,
    input  ram_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/ram_dump_ctrl.sv
// RAM read-out sequencer: walks START_ADDR..END_ADDR (wrapping) and streams each byte to the UART TX.
// Optional feature macro CHECKSUM_EN appends one XOR checksum byte after the last data byte.
`timescale 1ns/1ps
module ram_dump_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 255
) (
  input  logic            clk,
  input  logic            rst,
  ram_dump_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] L_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] L_END   = ADDR_W'(END_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    SEND,
    CSUM,
    FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_tx_data_nxt;
  logic              r_tx_valid;
  logic              w_tx_valid_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_hs;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] w_csum_nxt;
`endif

  assign w_hs = r_tx_valid & bus.tx_ready;

  // RD0 lets the RAM latch the address; its registered output is sampled in RD1.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
`ifdef CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_addr_nxt  = L_START;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RD0;
`ifdef CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
        end
      end
      RD0: w_state_nxt = RD1;
      RD1: begin
        w_tx_data_nxt  = bus.ram_q;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = SEND;
      end
      SEND: begin
        if (w_hs) begin
          w_tx_valid_nxt = 1'b0;
`ifdef CHECKSUM_EN
          w_csum_nxt = r_csum ^ r_tx_data;
          if (r_addr == L_END) begin
            // Checksum byte is offered on the very next cycle, so valid stays up.
            w_tx_data_nxt  = r_csum ^ r_tx_data;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = CSUM;
          end else begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = RD0;
          end
`else
          if (r_addr == L_END) begin
            w_state_nxt = FIN;
          end else begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = RD0;
          end
`endif
        end
      end
`ifdef CHECKSUM_EN
      CSUM: begin
        if (w_hs) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = FIN;
        end
      end
`endif
      FIN: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
`ifdef CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  assign bus.ram_addr = r_addr;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = (r_state == FIN);

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Directed bench for ram_dump_ctrl: full dump, random back-pressure, wrapped window, start filtering, mid-dump reset.
// Build with +define+CHECKSUM_EN to also expect the trailing checksum byte.
`timescale 1ns/1ps
module tb_ram_dump_ctrl;

`ifdef CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   nVec;
  int   nFail;

  ram_dump_ctrl_if #(.ADDR_W(8), .DATA_W(8)) busA ();
  ram_dump_ctrl_if #(.ADDR_W(8), .DATA_W(8)) busB ();

  ram_dump_ctrl #(.ADDR_W(8), .DATA_W(8), .START_ADDR(0), .END_ADDR(255)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.master)
  );

  ram_dump_ctrl #(.ADDR_W(8), .DATA_W(8), .START_ADDR(254), .END_ADDR(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models with one-cycle registered read, mem[a] = a ^ 8'h5A
  always @(posedge clk) begin
    busA.ram_q <= busA.ram_addr ^ 8'h5A;
    busB.ram_q <= busB.ram_addr ^ 8'h5A;
  end

  logic [7:0] capA[$];
  int         edgeA[$];
  logic [7:0] capB[$];
  logic [7:0] addrB[$];
  int         violA;
  int         doneCntA;
  int         doneCntB;
  bit         pendA;
  logic [7:0] pendDataA;

  // Sampled on the falling edge: a valid&&ready seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      pendA = 1'b0;
    end else begin
      if (busA.tx_valid && busA.tx_ready) begin
        capA.push_back(busA.tx_data);
        edgeA.push_back(cyc + 1);
      end
      if (pendA && (!busA.tx_valid || busA.tx_data !== pendDataA)) violA++;
      pendA     = busA.tx_valid && !busA.tx_ready;
      pendDataA = busA.tx_data;
      if (busA.done) doneCntA++;
      if (busB.tx_valid && busB.tx_ready) begin
        capB.push_back(busB.tx_data);
        addrB.push_back(busB.ram_addr);
      end
      if (busB.done) doneCntB++;
    end
  end

  task automatic applyStart(input bit selB, output int k);
    @(posedge clk); #1;
    if (selB) busB.start = 1'b1;
    else      busA.start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    busA.start = 1'b0;
    busB.start = 1'b0;
  endtask

  task automatic waitDone(input bit selB, input int bound, output int m, output bit seen);
    seen = 1'b0;
    m    = 0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(posedge clk); #1;
      if ((selB ? busB.done : busA.done) === 1'b1) begin
        seen = 1'b1;
        m    = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nVec++; if (busA.tx_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tx_valid: got %b, expected 0", busA.tx_valid); end
    nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busA.busy); end
    nVec++; if (busA.done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b, expected 0", busA.done); end
    nVec++; if (busA.ram_addr !== 8'h00) begin nFail++; $display("[TB] FAIL reset_ram_addr: got %02h, expected 00", busA.ram_addr); end
    nVec++; if (busA.tx_data !== 8'h00) begin nFail++; $display("[TB] FAIL reset_tx_data: got %02h, expected 00", busA.tx_data); end
    nVec++; if (busB.ram_addr !== 8'h00) begin nFail++; $display("[TB] FAIL reset_ram_addr_b: got %02h, expected 00", busB.ram_addr); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_dump;
    int k, m, d0;
    bit seen;
    logic [7:0] exp;
    capA.delete(); edgeA.delete();
    busA.tx_ready = 1'b1;
    d0 = doneCntA;
    applyStart(1'b0, k);
    nVec++; if (busA.busy !== 1'b1) begin nFail++; $display("[TB] FAIL full_busy_rise: got %b, expected 1", busA.busy); end
    nVec++; if (busA.ram_addr !== 8'h00) begin nFail++; $display("[TB] FAIL full_start_addr: got %02h, expected 00", busA.ram_addr); end
    waitDone(1'b0, 1000, m, seen);
    nVec++; if (!seen) begin nFail++; $display("[TB] FAIL full_done_timeout: got no done, expected done"); end
    nVec++; if (m !== k + 768 + EXTRA) begin nFail++; $display("[TB] FAIL full_done_edge: got %0d, expected %0d", m - k, 768 + EXTRA); end
    nVec++; if (busA.busy !== 1'b1) begin nFail++; $display("[TB] FAIL full_busy_at_done: got %b, expected 1", busA.busy); end
    nVec++; if (capA.size() !== 256 + EXTRA) begin nFail++; $display("[TB] FAIL full_count: got %0d, expected %0d", capA.size(), 256 + EXTRA); end
    for (int i = 0; i < 256; i++) begin
      if (i < capA.size()) begin
        exp = 8'(i) ^ 8'h5A;
        nVec++; if (capA[i] !== exp) begin nFail++; $display("[TB] FAIL full_byte[%0d]: got %02h, expected %02h", i, capA[i], exp); end
        nVec++; if (edgeA[i] !== k + 3 + 3 * i) begin nFail++; $display("[TB] FAIL full_edge[%0d]: got %0d, expected %0d", i, edgeA[i] - k, 3 + 3 * i); end
      end
    end
`ifdef CHECKSUM_EN
    if (capA.size() > 256) begin
      nVec++; if (capA[256] !== 8'h00) begin nFail++; $display("[TB] FAIL full_csum: got %02h, expected 00", capA[256]); end
      nVec++; if (edgeA[256] !== k + 769) begin nFail++; $display("[TB] FAIL full_csum_edge: got %0d, expected 769", edgeA[256] - k); end
    end
`endif
    @(posedge clk); #1;
    nVec++; if (busA.done !== 1'b0) begin nFail++; $display("[TB] FAIL full_done_width: got %b, expected 0", busA.done); end
    nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("[TB] FAIL full_busy_fall: got %b, expected 0", busA.busy); end
    repeat (2) @(posedge clk); #1;
    nVec++; if (doneCntA - d0 !== 1) begin nFail++; $display("[TB] FAIL full_done_count: got %0d, expected 1", doneCntA - d0); end
  endtask

  task automatic test_random_ready;
    int k, v0, d0, lowCnt, sizeSeen;
    bit seen;
    logic [7:0] exp;
    capA.delete(); edgeA.delete();
    busA.tx_ready = 1'b0;
    v0 = violA; d0 = doneCntA;
    lowCnt = 10; sizeSeen = 0; seen = 1'b0;
    applyStart(1'b0, k);
    for (int c = 0; c < 12000 && !seen; c++) begin
      @(posedge clk); #1;
      if (busA.done === 1'b1) seen = 1'b1;
      if (capA.size() != sizeSeen) begin
        sizeSeen = capA.size();
        lowCnt   = 10 + $urandom_range(0, 3);
      end
      if (lowCnt > 0) begin
        busA.tx_ready = 1'b0;
        lowCnt--;
      end else begin
        busA.tx_ready = 1'($urandom_range(0, 1));
      end
    end
    busA.tx_ready = 1'b0;
    nVec++; if (!seen) begin nFail++; $display("[TB] FAIL rand_done_timeout: got no done, expected done"); end
    nVec++; if (capA.size() !== 256 + EXTRA) begin nFail++; $display("[TB] FAIL rand_count: got %0d, expected %0d", capA.size(), 256 + EXTRA); end
    for (int i = 0; i < 256; i++) begin
      if (i < capA.size()) begin
        exp = 8'(i) ^ 8'h5A;
        nVec++; if (capA[i] !== exp) begin nFail++; $display("[TB] FAIL rand_byte[%0d]: got %02h, expected %02h", i, capA[i], exp); end
      end
    end
`ifdef CHECKSUM_EN
    if (capA.size() > 256) begin
      nVec++; if (capA[256] !== 8'h00) begin nFail++; $display("[TB] FAIL rand_csum: got %02h, expected 00", capA[256]); end
    end
`endif
    repeat (3) @(posedge clk); #1;
    nVec++; if (violA - v0 !== 0) begin nFail++; $display("[TB] FAIL rand_stall_stability: got %0d changes, expected 0", violA - v0); end
    nVec++; if (doneCntA - d0 !== 1) begin nFail++; $display("[TB] FAIL rand_done_count: got %0d, expected 1", doneCntA - d0); end
  endtask

  task automatic test_wrap_window;
    int k, m, n0;
    bit seen;
    logic [7:0] expD[4] = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
    logic [7:0] expA[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    capB.delete(); addrB.delete();
    busB.tx_ready = 1'b1;
    applyStart(1'b1, k);
    nVec++; if (busB.ram_addr !== 8'hFE) begin nFail++; $display("[TB] FAIL wrap_start_addr: got %02h, expected fe", busB.ram_addr); end
    waitDone(1'b1, 100, m, seen);
    nVec++; if (!seen) begin nFail++; $display("[TB] FAIL wrap_done_timeout: got no done, expected done"); end
    nVec++; if (m !== k + 12 + EXTRA) begin nFail++; $display("[TB] FAIL wrap_done_edge: got %0d, expected %0d", m - k, 12 + EXTRA); end
    nVec++; if (capB.size() !== 4 + EXTRA) begin nFail++; $display("[TB] FAIL wrap_count: got %0d, expected %0d", capB.size(), 4 + EXTRA); end
    for (int i = 0; i < 4; i++) begin
      if (i < capB.size()) begin
        nVec++; if (capB[i] !== expD[i]) begin nFail++; $display("[TB] FAIL wrap_byte[%0d]: got %02h, expected %02h", i, capB[i], expD[i]); end
        nVec++; if (addrB[i] !== expA[i]) begin nFail++; $display("[TB] FAIL wrap_addr[%0d]: got %02h, expected %02h", i, addrB[i], expA[i]); end
      end
    end
`ifdef CHECKSUM_EN
    if (capB.size() > 4) begin
      nVec++; if (capB[4] !== 8'h00) begin nFail++; $display("[TB] FAIL wrap_csum: got %02h, expected 00", capB[4]); end
    end
`endif
    // start presented while in FIN must be dropped
    n0 = capB.size();
    busB.start = 1'b1;
    @(posedge clk); #1;
    busB.start = 1'b0;
    nVec++; if (busB.busy !== 1'b0) begin nFail++; $display("[TB] FAIL wrap_fin_start_busy: got %b, expected 0", busB.busy); end
    repeat (6) @(posedge clk); #1;
    nVec++; if (busB.busy !== 1'b0) begin nFail++; $display("[TB] FAIL wrap_fin_start_idle: got %b, expected 0", busB.busy); end
    nVec++; if (capB.size() !== n0) begin nFail++; $display("[TB] FAIL wrap_fin_start_bytes: got %0d, expected %0d", capB.size(), n0); end
  endtask

  task automatic test_start_filter;
    int k, m, d0, k2, m2;
    bit seen;
    capA.delete(); edgeA.delete();
    busA.tx_ready = 1'b1;
    d0 = doneCntA;
    applyStart(1'b0, k);
    seen = 1'b0; m = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(posedge clk); #1;
      busA.start = (cyc == k + 4 || cyc == k + 99) ? 1'b1 : 1'b0;
      if (busA.done === 1'b1) begin seen = 1'b1; m = cyc; end
    end
    busA.start = 1'b0;
    nVec++; if (!seen) begin nFail++; $display("[TB] FAIL filt_done_timeout: got no done, expected done"); end
    nVec++; if (m !== k + 768 + EXTRA) begin nFail++; $display("[TB] FAIL filt_done_edge: got %0d, expected %0d", m - k, 768 + EXTRA); end
    nVec++; if (capA.size() !== 256 + EXTRA) begin nFail++; $display("[TB] FAIL filt_count: got %0d, expected %0d", capA.size(), 256 + EXTRA); end
    // start one cycle after done launches a fresh dump
    applyStart(1'b0, k2);
    nVec++; if (busA.busy !== 1'b1) begin nFail++; $display("[TB] FAIL back_to_back_busy: got %b, expected 1", busA.busy); end
    waitDone(1'b0, 1000, m2, seen);
    nVec++; if (!seen) begin nFail++; $display("[TB] FAIL back_to_back_timeout: got no done, expected done"); end
    nVec++; if (m2 !== k2 + 768 + EXTRA) begin nFail++; $display("[TB] FAIL back_to_back_done_edge: got %0d, expected %0d", m2 - k2, 768 + EXTRA); end
    nVec++; if (capA.size() !== 2 * (256 + EXTRA)) begin nFail++; $display("[TB] FAIL back_to_back_count: got %0d, expected %0d", capA.size(), 2 * (256 + EXTRA)); end
    if (capA.size() > 256 + EXTRA) begin
      nVec++; if (capA[256 + EXTRA] !== 8'h5A) begin nFail++; $display("[TB] FAIL back_to_back_first: got %02h, expected 5a", capA[256 + EXTRA]); end
    end
    repeat (2) @(posedge clk); #1;
    nVec++; if (doneCntA - d0 !== 2) begin nFail++; $display("[TB] FAIL back_to_back_done_count: got %0d, expected 2", doneCntA - d0); end
  endtask

  task automatic test_reset_mid_dump;
    int k, d0;
    bit hit;
    capA.delete(); edgeA.delete();
    busA.tx_ready = 1'b1;
    applyStart(1'b0, k);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      if (capA.size() == 5) begin busA.tx_ready = 1'b0; hit = 1'b1; end
    end
    nVec++; if (!hit) begin nFail++; $display("[TB] FAIL rstmid_prefill_timeout: got %0d bytes, expected 5", capA.size()); end
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      if (busA.tx_valid === 1'b1) hit = 1'b1;
    end
    nVec++; if (!hit) begin nFail++; $display("[TB] FAIL rstmid_valid_timeout: got tx_valid=0, expected 1"); end
    nVec++; if (busA.ram_addr !== 8'h05) begin nFail++; $display("[TB] FAIL rstmid_addr_before: got %02h, expected 05", busA.ram_addr); end
    d0 = doneCntA;
    @(negedge clk);
    rst = 1'b1;
    #1;
    nVec++; if (busA.tx_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_tx_valid: got %b, expected 0", busA.tx_valid); end
    nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", busA.busy); end
    nVec++; if (busA.ram_addr !== 8'h00) begin nFail++; $display("[TB] FAIL rstmid_ram_addr: got %02h, expected 00", busA.ram_addr); end
    nVec++; if (busA.tx_data !== 8'h00) begin nFail++; $display("[TB] FAIL rstmid_tx_data: got %02h, expected 00", busA.tx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busA.tx_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    nVec++; if (busA.busy !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_stay_idle: got %b, expected 0", busA.busy); end
    nVec++; if (busA.tx_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_no_valid: got %b, expected 0", busA.tx_valid); end
    nVec++; if (doneCntA - d0 !== 0) begin nFail++; $display("[TB] FAIL rstmid_no_done: got %0d, expected 0", doneCntA - d0); end
    nVec++; if (capA.size() !== 5) begin nFail++; $display("[TB] FAIL rstmid_no_more_bytes: got %0d, expected 5", capA.size()); end
    applyStart(1'b0, k);
    nVec++; if (busA.busy !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_restart: got %b, expected 1", busA.busy); end
  endtask

  initial begin
    nVec = 0; nFail = 0;
    violA = 0; doneCntA = 0; doneCntB = 0;
    pendA = 1'b0; pendDataA = 8'h00;
    rst = 1'b1;
    busA.start = 1'b0; busA.tx_ready = 1'b0;
    busB.start = 1'b0; busB.tx_ready = 1'b0;
    $display("[TB] ram_dump_ctrl bench, checksum byte count %0d", EXTRA);
    test_reset();
    test_full_dump();
    test_random_ready();
    test_wrap_window();
    test_start_filter();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
